// File: rtl/shiftrows_mixcols_seq.sv
// Purpose : AES round stage after SubBytes: (Inv)ShiftRows then column-serial (Inv)MixColumns.
// Latency : out_valid rises 4 edges after accept (1 with SHIFTMIX_PARALLEL_EN), 0 edges for last_round.
// Backpressure: in_ready low outside IDLE; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   mode               0 = forward (ShiftRows + MixColumns), 1 = inverse (InvShiftRows + InvMixColumns)
//   last_round         1 = shift only, mix step skipped
//   in_valid/in_ready  input handshake for state/mode/last_round
//   state              128-bit input; byte i = state[127-8i -: 8], row = i%4, col = i/4
//   out_valid/out_ready output handshake for state_out
//   state_out          128-bit result, same byte mapping as state
//   busy               high whenever the FSM is not IDLE
//
// Build option: define SHIFTMIX_PARALLEL_EN to mix all four columns in a single MIX cycle.
// Parameter CLEAR_ON_POP: 1 clears state_out on the consuming handshake, 0 holds it.

module shiftrows_mixcols_seq #(
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         last_round,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    // One-hot encoding so each handshake output is a single flop bit.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        MIX  = 3'b010,
        DONE = 3'b100
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic         mode_q, mode_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;

    // ------------------------------------------------------------------
    // GF(2^8) helpers (polynomial 0x11b)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward: out[r][c] = in[r][(c+r)%4]; inverse: out[r][c] = in[r][(c-r)%4].
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] res;
        logic [1:0]   src;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? 2'(c - r) : 2'(c + r);
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*int'(src)+r) -: 8];
            end
        end
        return res;
    endfunction

    // One column, row 0 in the MSB byte. Matrix rows are rotations of the
    // first row, so the coefficient depends only on (j - r) mod 4.
    // Inverse coefficients are built from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  term;
        logic [1:0]  k;
        logic [31:0] res;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[31-8*j -: 8];
            x2[j] = xtime(a[j]);
            x4[j] = xtime(x2[j]);
            x8[j] = xtime(x4[j]);
        end
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                k = 2'(j - r);
                if (!inv) begin
                    case (k)
                        2'd0:    term = x2[j];              // 02
                        2'd1:    term = x2[j] ^ a[j];       // 03
                        default: term = a[j];               // 01
                    endcase
                end else begin
                    case (k)
                        2'd0:    term = x8[j] ^ x4[j] ^ x2[j];  // 0e
                        2'd1:    term = x8[j] ^ x2[j] ^ a[j];   // 0b
                        2'd2:    term = x8[j] ^ x4[j] ^ a[j];   // 0d
                        default: term = x8[j] ^ a[j];           // 09
                    endcase
                end
                res[31-8*r -: 8] = res[31-8*r -: 8] ^ term;
            end
        end
        return res;
    endfunction

`ifndef SHIFTMIX_PARALLEL_EN
    // Single shared mixer: select the column addressed by col_q.
    logic [31:0] col_sel;
    logic [31:0] col_mix;

    always_comb begin
        col_sel = '0;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                col_sel = work_q[127-32*c -: 32];
            end
        end
    end

    assign col_mix = mix_column(col_sel, mode_q);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            mode_q <= 1'b0;
            col_q  <= 2'd0;
            work_q <= '0;
            out_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            mode_q <= mode_d;
            col_q  <= col_d;
            work_q <= work_d;
            out_q  <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d  = fsm_q;
        mode_d = mode_q;
        col_d  = col_q;
        work_d = work_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d = mode;
                    col_d  = 2'd0;
                    work_d = shift_rows(state, mode);
                    fsm_d  = last_round ? DONE : MIX;
                end
            end
            MIX: begin
`ifdef SHIFTMIX_PARALLEL_EN
                for (int c = 0; c < 4; c++) begin
                    work_d[127-32*c -: 32] = mix_column(work_q[127-32*c -: 32], mode_q);
                end
                fsm_d = DONE;
`else
                for (int c = 0; c < 4; c++) begin
                    if (col_q == 2'(c)) begin
                        work_d[127-32*c -: 32] = col_mix;
                    end
                end
                // Counter wraps 3 -> 0, leaving it at 0 for the next block.
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: handshake flags are flop bits of the one-hot state; the
    // result register loads on entry to DONE and optionally clears on pop.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = fsm_q[0];
        busy      = ~fsm_q[0];
        out_valid = fsm_q[2];
        out_d     = out_q;
        if ((fsm_d == DONE) && (fsm_q != DONE)) begin
            out_d = work_d;
        end else if ((fsm_q == DONE) && out_ready && CLEAR_ON_POP) begin
            out_d = '0;
        end
    end

    assign state_out = out_q;

endmodule

// File: doc/shiftrows_mixcols_seq.md
Name: shiftrows_mixcols_seq

Overview:
Round stage directly downstream of subbytes_generic. It takes the 128-bit substituted state and applies ShiftRows then MixColumns in forward mode. In inverse mode it applies InvShiftRows then InvMixColumns, the equivalent-inverse-cipher order. MixColumns is column-serial, one column per cycle, behind a valid/ready handshake. A last_round input skips the mix step for the final AES round.

Parameters:
CLEAR_ON_POP, 1, when 1 state_out clears to 0 on the handshake that consumes it; when 0 state_out holds its last value.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
mode  input  1  0 = forward (ShiftRows + MixColumns); 1 = inverse (InvShiftRows + InvMixColumns).
last_round  input  1  1 = shift only, no column mixing.
in_valid  input  1  state, mode and last_round are valid.
in_ready  output  1  block can accept a new state.
state  input  128  input state; byte i = state[127-8i -: 8], row = i%4, col = i/4.
out_valid  output  1  state_out is valid.
out_ready  input  1  consumer accepts state_out.
state_out  output  128  result, same byte mapping as state.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, in_ready=1, out_valid=0, busy=0, state_out=0, column counter=0, internal work register=0.
- FSM states: IDLE, MIX, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0:
  - capture mode and last_round;
  - load the work register with the shifted state. Forward: out[r][c]=in[r][(c+r)%4]. Inverse: out[r][c]=in[r][(c-r)%4].
  - next state is DONE if last_round=1, otherwise MIX with col=0.
- MIX: each cycle replace column col of the work register with its mixed value; col increments 0..3. After col=3, go to DONE. Exactly 4 cycles.
  - Forward matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
  - Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - GF(2^8) multiply uses polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0). The 0e/0b/0d/09 products are built from xtime chains.
- DONE: out_valid=1 and state_out = work register. Both hold stable while out_ready=0. On out_valid&&out_ready, go to IDLE; apply CLEAR_ON_POP.
- Latency, counted from the accepting edge E0:
  - mix round: out_valid rises after edge E0+4.
  - last_round: out_valid rises after edge E0+0, i.e. in the cycle after acceptance.
- Throughput: in_ready=0 outside IDLE, so there is no overlap. A new accept is possible the cycle after a pop; minimum spacing is 6 cycles for mix rounds and 2 for last rounds.
- While busy, changes on state, mode, last_round and in_valid are ignored. Captured copies are used.
- out_ready asserted while out_valid=0 has no effect.
- Asserting rst in MIX or DONE aborts the operation immediately. The partial result is discarded and all outputs return to reset values.
- All outputs are registered; there is no combinational path from in_valid to out_valid.

Optional Feature:
SHIFTMIX_PARALLEL_EN
- Defined: MIX lasts one cycle and mixes all four columns at once. Mix-round latency becomes E0+1. Column counter is unused and stays at 0.
- Undefined: column-serial operation as above, with 4 MIX cycles.
- Results are bit-identical in both builds; only timing differs.

Test Plan:
- Reset:
  - rst=1 mid-MIX (2nd column) -> next sample shows out_valid=0, in_ready=1, state_out=0.
  - After release, the next transaction completes normally.
- Forward FIPS-197 round 1: mode=0, last_round=0, state=d42711aee0bf98f1b8b45de51e415230 -> state_out=046681e5e0cb199a48f8d37a2806264c. out_valid rises exactly 4 edges after accept (1 with SHIFTMIX_PARALLEL_EN).
- Forward last round: mode=0, last_round=1, same input -> state_out=d4bf5d30e0b452aeb84111f11e2798e5, out_valid the cycle after accept.
- Inverse mix:
  - mode=1, last_round=0, state=8e4da1bc8e4da1bc8e4da1bc8e4da1bc -> state_out=db135345db135345db135345db135345.
  - Same test with mode=0 and input/output swapped.
- Inverse shift only: mode=1, last_round=1, state=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out=d42711aee0bf98f1b8b45de51e415230.
- Backpressure:
  - out_ready=0 for 5 cycles with state=6363…63 (mode=0) -> state_out=6363…63 held stable, in_ready=0, and a changing input state is ignored.
  - On out_ready=1, a single pop occurs; state_out becomes 0 when CLEAR_ON_POP=1.
